// File: rtl/next_line_prefetcher_if.sv
// Bus bundle between the next-line prefetcher, its cache and the pmem arbiter.
//  Cache side  : prefetch_start, cacheline_address, cache_way (to prefetcher)
//                prefetch_rdata, prefetch_ready, pf_cline_address, pf_cache_way (from prefetcher)
//  Memory side : demand_busy, pf_pmem_rdata, pf_pmem_resp (to prefetcher)
//                pf_pmem_read, pf_pmem_address (from prefetcher)
//  modport master : the prefetcher itself
//  modport slave  : the cache / memory environment around it
interface next_line_prefetcher_if #(
  parameter int s_offset = 5,
  parameter int s_line   = 256
);
  logic              prefetch_start;
  logic [31:0]       cacheline_address;
  logic              cache_way;
  logic [s_line-1:0] prefetch_rdata;
  logic              prefetch_ready;
  logic [31:0]       pf_cline_address;
  logic              pf_cache_way;
  logic              demand_busy;
  logic              pf_pmem_read;
  logic [31:0]       pf_pmem_address;
  logic [s_line-1:0] pf_pmem_rdata;
  logic              pf_pmem_resp;

  modport master (
    input  prefetch_start, cacheline_address, cache_way, demand_busy,
           pf_pmem_rdata, pf_pmem_resp,
    output prefetch_rdata, prefetch_ready, pf_cline_address, pf_cache_way,
           pf_pmem_read, pf_pmem_address
  );

  modport slave (
    output prefetch_start, cacheline_address, cache_way, demand_busy,
           pf_pmem_rdata, pf_pmem_resp,
    input  prefetch_rdata, prefetch_ready, pf_cline_address, pf_cache_way,
           pf_pmem_read, pf_pmem_address
  );
endinterface

// File: rtl/next_line_prefetcher.sv
// Sequential next-line prefetcher. On each demand-miss pulse it fetches the line
// following the missing one from pmem and hands it back with its address and way.
// One request is active (ARB/READ/DONE) and one more may wait in a pending slot.
// Ports:
//  clk  : clock
//  rst  : synchronous active-high reset
//  bus  : next_line_prefetcher_if.master (cache request/response + pmem read port)
module next_line_prefetcher #(
  parameter int s_offset = 5,
  parameter int s_line   = 256
) (
  input logic                   clk,
  input logic                   rst,
  next_line_prefetcher_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [31:0]       active_addr;
  logic              active_way;
  logic [31:0]       pend_addr;
  logic              pend_way;
  logic              pend_valid;

  logic [s_line-1:0] rdata_q;
  logic [31:0]       cline_q;
  logic              way_q;
  logic              ready_q;
  logic              read_q;

  logic [31:0]       line_base;
  logic [32:0]       target_sum;
  logic [31:0]       target;
  logic              dup;
  logic              start_ok;

  // Target line address, wrap detection and duplicate filtering of a new start.
  always_comb begin
    line_base  = bus.cacheline_address & ~((32'd1 << s_offset) - 32'd1);
    target_sum = {1'b0, line_base} + (33'd1 << s_offset);
    target     = target_sum[31:0];
    // A request already active (ARB/READ/DONE) or waiting absorbs an identical one.
    dup        = ((state != IDLE) && (target == active_addr)) ||
                 (pend_valid && (target == pend_addr));
    // Carry out of bit 31 means the next line would wrap to 0: drop it.
    start_ok   = bus.prefetch_start && !target_sum[32] && !dup;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) state_next = ARB;
        else          state_next = IDLE;
      end
      ARB: begin
        // Demand traffic owns pmem; only start a read in a free cycle.
        if (bus.demand_busy) state_next = ARB;
        else                 state_next = READ;
      end
      READ: begin
        if (bus.pf_pmem_resp) state_next = DONE;
        else                  state_next = READ;
      end
      DONE: begin
        // A waiting or simultaneously arriving request is served before idling.
        if (pend_valid || start_ok) state_next = ARB;
        else                        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Active/pending request slots, delivered line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_addr <= 32'd0;
      active_way  <= 1'b0;
      pend_addr   <= 32'd0;
      pend_way    <= 1'b0;
      pend_valid  <= 1'b0;
      rdata_q     <= {s_line{1'b0}};
      cline_q     <= 32'd0;
      way_q       <= 1'b0;
      ready_q     <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      ready_q <= (state_next == DONE);
      read_q  <= (state_next == READ);
      case (state)
        IDLE: begin
          if (start_ok) begin
            active_addr <= target;
            active_way  <= bus.cache_way;
          end
        end
        ARB, READ: begin
          // Only the most recent start is kept in the pending slot.
          if (start_ok) begin
            pend_addr  <= target;
            pend_way   <= bus.cache_way;
            pend_valid <= 1'b1;
          end
          if ((state == READ) && bus.pf_pmem_resp) begin
            rdata_q <= bus.pf_pmem_rdata;
            cline_q <= active_addr;
            way_q   <= active_way;
          end
        end
        DONE: begin
          if (pend_valid) begin
            // Pending becomes active; a start in this cycle refills the slot.
            active_addr <= pend_addr;
            active_way  <= pend_way;
            pend_valid  <= start_ok;
            if (start_ok) begin
              pend_addr <= target;
              pend_way  <= bus.cache_way;
            end
          end else if (start_ok) begin
            active_addr <= target;
            active_way  <= bus.cache_way;
          end
        end
        default: begin
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prefetch_rdata   = rdata_q;
  assign bus.prefetch_ready   = ready_q;
  assign bus.pf_cline_address = cline_q;
  assign bus.pf_cache_way     = way_q;
  assign bus.pf_pmem_read     = read_q;
  // active_addr only changes outside READ, so the address is stable while reading.
  assign bus.pf_pmem_address  = active_addr;

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Self-checking bench for next_line_prefetcher: a pmem responder model with a
// programmable latency, and a scoreboard of expected delivered lines.
module tb_next_line_prefetcher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  next_line_prefetcher_if bus ();

  next_line_prefetcher dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic         way;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int reads    = 0;
  int readies  = 0;
  int addr_glitch   = 0;
  int last_resp_cyc = 0;
  int resp_delay    = 5;
  bit read_prev     = 1'b0;

  bit          rsp_pending = 1'b0;
  int          rsp_cnt     = 0;
  logic [31:0] rsp_addr    = 32'd0;

  function automatic logic [255:0] pat(input logic [31:0] a);
    pat = {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_1111, {a[15:0], a[31:16]},
           ~a ^ 32'h0F0F_0F0F, a - 32'h0000_0101, 32'hC0DE_0000 | a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // pmem model: answers each read resp_delay cycles after it is first seen.
  always @(negedge clk) begin
    if (rsp_pending) begin
      if (bus.pf_pmem_read === 1'b1 && bus.pf_pmem_address !== rsp_addr)
        addr_glitch <= addr_glitch + 1;
      if (rsp_cnt <= 1) begin
        bus.pf_pmem_resp  <= 1'b1;
        bus.pf_pmem_rdata <= pat(rsp_addr);
        rsp_pending       <= 1'b0;
        last_resp_cyc     <= cyc;
      end else begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end else begin
      bus.pf_pmem_resp <= 1'b0;
      if (bus.pf_pmem_read === 1'b1) begin
        rsp_pending <= 1'b1;
        rsp_cnt     <= resp_delay;
        rsp_addr    <= bus.pf_pmem_address;
      end
    end
  end

  // Counts read requests issued and ready pulses delivered.
  always @(negedge clk) begin
    if (bus.pf_pmem_read === 1'b1 && !read_prev) reads <= reads + 1;
    read_prev <= (bus.pf_pmem_read === 1'b1);
    if (bus.prefetch_ready === 1'b1) readies <= readies + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.prefetch_ready === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_read(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.pf_pmem_read === 1'b1) got = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic w);
    bus.prefetch_start    = 1'b1;
    bus.cacheline_address = a;
    bus.cache_way         = w;
    @(negedge clk);
    bus.prefetch_start    = 1'b0;
    bus.cacheline_address = 32'd0;
    bus.cache_way         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.prefetch_start = 1'b0; bus.cacheline_address = 32'd0;
    bus.cache_way = 1'b0;      bus.demand_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.prefetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.prefetch_ready); end
    n_checks++; if (bus.pf_pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", bus.pf_pmem_read); end
    n_checks++; if (bus.pf_pmem_address !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.pf_pmem_address); end
    n_checks++; if (bus.pf_cline_address !== 32'd0) begin n_fail++; $display("FAIL reset_cline: got %h expected 0", bus.pf_cline_address); end
    n_checks++; if (bus.pf_cache_way !== 1'b0) begin n_fail++; $display("FAIL reset_way: got %b expected 0", bus.pf_cache_way); end
    n_checks++; if (bus.prefetch_rdata !== 256'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.prefetch_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int r0, y0; bit got; exp_t e;
    resp_delay = 5; r0 = reads; y0 = readies;
    sb.push_back(exp_t'{32'h0000_1060, 1'b1, pat(32'h0000_1060)});
    pulse_start(32'h0000_1040, 1'b1);
    n_checks++; if (bus.pf_pmem_read !== 1'b0) begin n_fail++; $display("FAIL basic_read_early: got %b expected 0", bus.pf_pmem_read); end
    @(negedge clk);
    n_checks++; if (bus.pf_pmem_read !== 1'b1) begin n_fail++; $display("FAIL basic_read_latency: got %b expected 1", bus.pf_pmem_read); end
    n_checks++; if (bus.pf_pmem_address !== 32'h0000_1060) begin n_fail++; $display("FAIL basic_read_addr: got %h expected 00001060", bus.pf_pmem_address); end
    wait_ready(30, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL basic_ready_timeout: got none expected ready pulse"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (cyc - last_resp_cyc !== 1) begin n_fail++; $display("FAIL basic_ready_latency: got %0d expected 1", cyc - last_resp_cyc); end
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL basic_cline: got %h expected %h", bus.pf_cline_address, e.addr); end
      n_checks++; if (bus.pf_cache_way !== e.way) begin n_fail++; $display("FAIL basic_way: got %b expected %b", bus.pf_cache_way, e.way); end
      n_checks++; if (bus.prefetch_rdata !== e.data) begin n_fail++; $display("FAIL basic_rdata: got %h expected %h", bus.prefetch_rdata, e.data); end
      @(negedge clk);
      n_checks++; if (bus.prefetch_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_width: got %b expected 0", bus.prefetch_ready); end
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL basic_cline_hold: got %h expected %h", bus.pf_cline_address, e.addr); end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (reads - r0 !== 1) begin n_fail++; $display("FAIL basic_read_count: got %0d expected 1", reads - r0); end
    n_checks++; if (readies - y0 !== 1) begin n_fail++; $display("FAIL basic_ready_count: got %0d expected 1", readies - y0); end
  endtask

  task automatic test_busy();
    int hi; bit got; exp_t e;
    resp_delay = 3; hi = 0;
    bus.demand_busy = 1'b1;
    sb.push_back(exp_t'{32'h0000_2020, 1'b0, pat(32'h0000_2020)});
    pulse_start(32'h0000_2000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pf_pmem_read !== 1'b0) hi++;
    end
    n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL busy_read_blocked: got %0d high cycles expected 0", hi); end
    bus.demand_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.pf_pmem_read !== 1'b1) begin n_fail++; $display("FAIL busy_read_after_drop: got %b expected 1", bus.pf_pmem_read); end
    n_checks++; if (bus.pf_pmem_address !== 32'h0000_2020) begin n_fail++; $display("FAIL busy_read_addr: got %h expected 00002020", bus.pf_pmem_address); end
    bus.demand_busy = 1'b1;  // rising during READ must not disturb the read
    wait_ready(20, got);
    bus.demand_busy = 1'b0;
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL busy_ready_timeout: got none expected ready pulse"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL busy_cline: got %h expected %h", bus.pf_cline_address, e.addr); end
      n_checks++; if (bus.prefetch_rdata !== e.data) begin n_fail++; $display("FAIL busy_rdata: got %h expected %h", bus.prefetch_rdata, e.data); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pending();
    int r0, y0; bit got; exp_t e;
    resp_delay = 8; r0 = reads; y0 = readies;
    sb.push_back(exp_t'{32'h0000_3020, 1'b0, pat(32'h0000_3020)});
    pulse_start(32'h0000_3000, 1'b0);
    wait_read(10, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL pend_read_timeout: got none expected read"); end
    pulse_start(32'h0000_4000, 1'b0);
    pulse_start(32'h0000_5000, 1'b1);
    sb.push_back(exp_t'{32'h0000_5020, 1'b1, pat(32'h0000_5020)});
    for (int k = 0; k < 2; k++) begin
      wait_ready(30, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL pend_ready_timeout: got none expected pulse %0d", k); end
      else begin
        e = sb.pop_front();
        n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL pend_cline: got %h expected %h", bus.pf_cline_address, e.addr); end
        n_checks++; if (bus.pf_cache_way !== e.way) begin n_fail++; $display("FAIL pend_way: got %b expected %b", bus.pf_cache_way, e.way); end
        n_checks++; if (bus.prefetch_rdata !== e.data) begin n_fail++; $display("FAIL pend_rdata: got %h expected %h", bus.prefetch_rdata, e.data); end
      end
    end
    repeat (12) @(negedge clk);
    n_checks++; if (reads - r0 !== 2) begin n_fail++; $display("FAIL pend_read_count: got %0d expected 2", reads - r0); end
    n_checks++; if (readies - y0 !== 2) begin n_fail++; $display("FAIL pend_ready_count: got %0d expected 2", readies - y0); end
  endtask

  task automatic test_wrap_dup();
    int r0, y0; bit got; exp_t e;
    resp_delay = 6; r0 = reads; y0 = readies;
    pulse_start(32'hFFFF_FFE0, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (reads - r0 !== 0) begin n_fail++; $display("FAIL wrap_read_count: got %0d expected 0", reads - r0); end
    n_checks++; if (readies - y0 !== 0) begin n_fail++; $display("FAIL wrap_ready_count: got %0d expected 0", readies - y0); end
    sb.push_back(exp_t'{32'h0000_1020, 1'b1, pat(32'h0000_1020)});
    pulse_start(32'h0000_1000, 1'b1);
    wait_read(10, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL dup_read_timeout: got none expected read"); end
    pulse_start(32'h0000_1000, 1'b0);
    pulse_start(32'h0000_1010, 1'b0);
    wait_ready(30, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL dup_ready_timeout: got none expected ready pulse"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL dup_cline: got %h expected %h", bus.pf_cline_address, e.addr); end
      n_checks++; if (bus.pf_cache_way !== e.way) begin n_fail++; $display("FAIL dup_way: got %b expected %b", bus.pf_cache_way, e.way); end
    end
    repeat (12) @(negedge clk);
    n_checks++; if (reads - r0 !== 1) begin n_fail++; $display("FAIL dup_read_count: got %0d expected 1", reads - r0); end
    n_checks++; if (readies - y0 !== 1) begin n_fail++; $display("FAIL dup_ready_count: got %0d expected 1", readies - y0); end
  endtask

  task automatic test_reset_mid_read();
    int r0, y0; bit got; exp_t e;
    resp_delay = 4; r0 = reads; y0 = readies;
    pulse_start(32'h0000_6000, 1'b0);
    wait_read(10, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL rstmid_read_timeout: got none expected read"); end
    pulse_start(32'h0000_7000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.pf_pmem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_read_low: got %b expected 0", bus.pf_pmem_read); end
    repeat (10) @(negedge clk);
    n_checks++; if (readies - y0 !== 0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d expected 0", readies - y0); end
    n_checks++; if (reads - r0 !== 1) begin n_fail++; $display("FAIL rstmid_read_count: got %0d expected 1", reads - r0); end
    // A fresh request must be the only thing served afterwards.
    resp_delay = 2;
    sb.push_back(exp_t'{32'h0000_8020, 1'b1, pat(32'h0000_8020)});
    pulse_start(32'h0000_8000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.pf_pmem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_latency: got %b expected 1", bus.pf_pmem_read); end
    wait_ready(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rstmid_ready_timeout: got none expected ready pulse"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL rstmid_cline: got %h expected %h", bus.pf_cline_address, e.addr); end
    end
    repeat (12) @(negedge clk);
    n_checks++; if (reads - r0 !== 2) begin n_fail++; $display("FAIL rstmid_pending_cleared: got %0d reads expected 2", reads - r0); end
  endtask

  task automatic test_done_start();
    bit got; exp_t e;
    resp_delay = 3;
    sb.push_back(exp_t'{32'h0000_9020, 1'b0, pat(32'h0000_9020)});
    pulse_start(32'h0000_9000, 1'b0);
    wait_ready(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL done_ready1_timeout: got none expected ready pulse"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL done_cline1: got %h expected %h", bus.pf_cline_address, e.addr); end
      sb.push_back(exp_t'{32'h0000_A020, 1'b1, pat(32'h0000_A020)});
      pulse_start(32'h0000_A000, 1'b1);
      n_checks++; if (bus.pf_pmem_read !== 1'b0) begin n_fail++; $display("FAIL done_arb_read: got %b expected 0", bus.pf_pmem_read); end
      @(negedge clk);
      n_checks++; if (bus.pf_pmem_read !== 1'b1) begin n_fail++; $display("FAIL done_next_read: got %b expected 1", bus.pf_pmem_read); end
      n_checks++; if (bus.pf_pmem_address !== 32'h0000_A020) begin n_fail++; $display("FAIL done_next_addr: got %h expected 0000a020", bus.pf_pmem_address); end
      wait_ready(20, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL done_ready2_timeout: got none expected ready pulse"); end
      else begin
        e = sb.pop_front();
        n_checks++; if (bus.pf_cline_address !== e.addr) begin n_fail++; $display("FAIL done_cline2: got %h expected %h", bus.pf_cline_address, e.addr); end
        n_checks++; if (bus.pf_cache_way !== e.way) begin n_fail++; $display("FAIL done_way2: got %b expected %b", bus.pf_cache_way, e.way); end
        n_checks++; if (bus.prefetch_rdata !== e.data) begin n_fail++; $display("FAIL done_rdata2: got %h expected %h", bus.prefetch_rdata, e.data); end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_addr_stable();
    n_checks++; if (addr_glitch !== 0) begin n_fail++; $display("FAIL addr_stable: got %0d changes expected 0", addr_glitch); end
  endtask

  initial begin
    bus.pf_pmem_resp  = 1'b0;
    bus.pf_pmem_rdata = 256'd0;
    test_reset();
    test_basic();
    test_busy();
    test_pending();
    test_wrap_dup();
    test_reset_mid_read();
    test_done_start();
    test_addr_stable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
